mem_req_ctrl: RTL and testbench
===============================

# mem_req_ctrl

Request initiator for the slow main-memory model. Accepts single-word read/write requests from the cache/CPU side over a valid/ready handshake and drives the memory's enable/addr/we/data_in pins. It waits for the memory's completion flag and returns the result over a valid/ready response channel. It sits between the cache miss path and the main memory, so no client ever handles the memory's edge-triggered enable protocol directly.

## Interface
- ADDR_WIDTH, 10, word address width; matches a 1024-entry memory
- DATA_WIDTH, 32, data word width; equals memory BLOCK_SIZE
- TIMEOUT_CYCLES, 256, WAIT cycles before a request is abandoned (only with timeout feature)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- req_valid  in  1  client request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  client takes response
- rsp_data  out  DATA_WIDTH  memory word sampled at completion
- rsp_err  out  1  request timed out
- mem_enable  out  1  memory enable; each rising edge starts one memory access
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory data_out
- mem_done  in  1  memory requestComplete
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1, mem_enable=0. On req_valid, latch we/addr/wdata and go to ISSUE.
- ISSUE: mem_enable=1 for exactly one cycle. mem_done is ignored here because it may still hold the previous access's stale value. Go to WAIT.
- WAIT: mem_enable=1. On mem_done=1, capture mem_rdata into rsp_data, set rsp_err=0, and go to RESP.
- RESP: rsp_valid=1, mem_enable=0. On rsp_ready, go to IDLE. rsp_data and rsp_err stay stable while rsp_valid=1.
- Outputs mem_we, mem_addr and mem_wdata are driven from latched registers. They are stable from ISSUE through the end of WAIT.
- Writes: rsp_data returns the pre-write memory contents. The memory returns the old word and then writes.
- Exactly one request is in flight; there is no queueing.
- Reset: all outputs go to 0 and state goes to IDLE. This includes mem_enable, which drops asynchronously.
- Reset mid-WAIT abandons the access. The next request still produces a fresh mem_enable rising edge.

## Timing
- Accept at edge E0 (req_valid & req_ready). mem_enable rises just after E0.
- ISSUE→WAIT happens at E1. The earliest completion is sampled at E2.
- rsp_valid rises just after the edge that samples mem_done=1. Total request-to-response latency is memory latency + 1.
- The response is taken at the edge where rsp_valid & rsp_ready. req_ready rises after that edge.
- Back-to-back requests: mem_enable is low for ≥2 cycles (RESP + IDLE), guaranteeing a clean rising edge per access.
- With memory DELAY=50: mem_done is seen about 50 cycles after mem_enable rises.

## Configuration
- Macro MEM_REQ_TIMEOUT_EN defined:
  - A WAIT-cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering ISSUE and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES without mem_done, go to RESP with rsp_err=1 and rsp_data=0.
  - If mem_done and timeout occur in the same cycle, mem_done wins (rsp_err=0).
- Macro undefined:
  - There is no counter, and rsp_err is tied to 0.
  - WAIT persists until mem_done.

## Structure
- Package mem_req_pkg holds:
  - the state enum typedef (IDLE/ISSUE/WAIT/RESP)
  - default ADDR_WIDTH and DATA_WIDTH
  - the default TIMEOUT_CYCLES constant
- One sub-module, mem_req_timer, is the timeout counter with clear/enable/expired. It is instantiated only under MEM_REQ_TIMEOUT_EN.

## Test plan
- Read at addr 10 against the memory model with DELAY=50 and contents mem[i]=i. Required: exactly one mem_enable rising edge, then rsp_valid with rsp_data=10 and rsp_err=0.
- Write addr 50 with data 0xDEAD, then read addr 50. Required: the write response has rsp_data=50, and the read response has rsp_data=0xDEAD.
- Two consecutive reads (addr 50, addr 50) with rsp_ready held high. Required: mem_enable is low ≥2 cycles between accesses, and both responses are 50.
- Hold rsp_ready=0 for 20 cycles after completion. Required: rsp_valid and rsp_data stay stable, req_ready=0, and no new memory access starts.
- Assert reset mid-WAIT. Required: mem_enable=0 and busy=0 immediately. A following read at addr 7 then returns 7.
- With MEM_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16 and mem_done tied 0: rsp_valid is required 16 WAIT cycles after entry, with rsp_err=1 and rsp_data=0.

Source files
------------

// File: rtl/mem_req_pkg.sv
// rtl/mem_req_pkg.sv - shared types and default sizes for the memory request controller
package mem_req_pkg;

    localparam int DEF_ADDR_WIDTH     = 10;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_req_if.sv
// rtl/mem_req_if.sv - client request/response channel plus memory pin bundle
interface mem_req_if #(
    parameter int ADDR_WIDTH = mem_req_pkg::DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = mem_req_pkg::DEF_DATA_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  mem_enable;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_done;

    // master is the controller: it serves the client and drives the memory pins
    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_enable, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata, mem_done,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_enable, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_req_timer.sv
// rtl/mem_req_timer.sv - WAIT-cycle counter; expired flags the last allowed WAIT cycle
module mem_req_timer
    import mem_req_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != CW'(TIMEOUT_CYCLES))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High on the WAIT cycle whose increment brings the count to TIMEOUT_CYCLES
    assign o_expired = i_enable && (r_count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_req_ctrl.sv
// rtl/mem_req_ctrl.sv - single-outstanding request initiator for the slow memory; timeout via MEM_REQ_TIMEOUT_EN
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
`ifdef MEM_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
    input  logic     clk,
    input  logic     reset,
    mem_req_if.master bus,
    output logic     busy
);
    state_t                r_state;
    logic                  r_req_ready;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_mem_enable;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_busy;
    logic                  w_accept;
    logic                  w_expired;

    assign w_accept = (r_state == S_IDLE) && bus.req_valid && r_req_ready;

`ifdef MEM_REQ_TIMEOUT_EN
    logic r_rsp_err;

    mem_req_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_accept),
        .i_enable (r_state == S_WAIT),
        .o_expired(w_expired)
    );

    assign bus.rsp_err = r_rsp_err;
`else
    assign w_expired   = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_mem_enable <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_busy       <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (w_accept) begin
                        r_mem_we     <= bus.req_we;
                        r_mem_addr   <= bus.req_addr;
                        r_mem_wdata  <= bus.req_wdata;
                        r_req_ready  <= 1'b0;
                        r_mem_enable <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                // mem_done may still show the previous access here, so it is not looked at
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (bus.mem_done) begin
                        r_rsp_data   <= bus.mem_rdata;
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
`ifdef MEM_REQ_TIMEOUT_EN
                        r_rsp_err    <= 1'b0;
`endif
                    end else if (w_expired) begin
                        r_rsp_data   <= '0;
                        r_mem_enable <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
`ifdef MEM_REQ_TIMEOUT_EN
                        r_rsp_err    <= 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.mem_enable = r_mem_enable;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign busy           = r_busy;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb/tb_mem_req_ctrl.sv - self-checking bench for mem_req_ctrl with a delayed memory model
`timescale 1ns/1ps
module tb_mem_req_ctrl;
    import mem_req_pkg::*;

`ifdef MEM_REQ_TIMEOUT_EN
    localparam int MEM_DELAY = 8;
    localparam int TO_CYC    = 16;
`else
    localparam int MEM_DELAY = 50;
`endif

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic kill_done = 1'b0;

    always #5 clk = ~clk;

    mem_req_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    mem_req_ctrl #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32)
`ifdef MEM_REQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO_CYC)
`endif
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy)
    );

    // Memory model: each enable rising edge starts an access that returns the old word after MEM_DELAY
    logic [31:0] mem [1024];
    logic        m_prev_en = 1'b0;
    logic        m_done    = 1'b0;
    logic [31:0] m_rdata   = '0;
    int          m_cnt     = 0;

    always @(posedge clk) begin
        m_prev_en <= bus.mem_enable;
        if (bus.mem_enable && !m_prev_en) begin
            m_done <= 1'b0;
            m_cnt  <= MEM_DELAY;
        end else if (m_cnt != 0) begin
            if (m_cnt == 1) begin
                m_rdata <= mem[bus.mem_addr];
                m_done  <= 1'b1;
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            end
            m_cnt <= m_cnt - 1;
        end
    end

    assign bus.mem_done  = m_done & ~kill_done;
    assign bus.mem_rdata = m_rdata;

    // Enable-edge monitor sampled on the falling edge
    int   en_rises = 0;
    int   low_run  = 0;
    int   min_gap  = 1000000;
    logic last_en  = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_enable) begin
            if (!last_en) begin
                if (en_rises > 0 && low_run < min_gap) min_gap = low_run;
                en_rises++;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        last_en = bus.mem_enable;
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] ref_mem [1024];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] d, output logic e);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_ready_timeout", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.rsp_valid) chk("rsp_valid_timeout", 32'(bus.rsp_valid), 32'd1);
        d = bus.rsp_data;
        e = bus.rsp_err;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [6];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, hold_d;
        logic        e;
        int          r0, k;
        logic        we;
        logic [9:0]  a;
        logic [31:0] wd, exp;

        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 32'(i);
            ref_mem[i] = 32'(i);
        end
        vt[0] = '{1'b0, 10'd10,   32'h0,    32'd10};
        vt[1] = '{1'b0, 10'd50,   32'h0,    32'd50};
        vt[2] = '{1'b0, 10'd50,   32'h0,    32'd50};
        vt[3] = '{1'b1, 10'd50,   32'hDEAD, 32'd50};
        vt[4] = '{1'b0, 10'd50,   32'h0,    32'hDEAD};
        vt[5] = '{1'b0, 10'd1023, 32'h0,    32'd1023};

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready",  32'(bus.req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(bus.rsp_valid),  32'd0);
        chk("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("rst_busy",       32'(busy),           32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);

        min_gap = 1000000;
        for (int i = 0; i < 6; i++) begin
            r0 = en_rises;
            do_req(vt[i].we, vt[i].addr, vt[i].wdata, d, e);
            chk($sformatf("vec%0d_data", i), d, vt[i].exp);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'd0);
            chk($sformatf("vec%0d_enable_rises", i), 32'(en_rises - r0), 32'd1);
            if (vt[i].we) ref_mem[vt[i].addr] = vt[i].wdata;
        end
        chk("b2b_enable_low_ge2", 32'(min_gap >= 2), 32'd1);

        // Response stall: rsp_ready low for 20 cycles while a request is also offered
        bus.rsp_ready = 1'b0;
        do_req(1'b0, 10'd5, 32'h0, hold_d, e);
        chk("stall_data", hold_d, ref_mem[5]);
        r0 = en_rises;
        bus.req_valid = 1'b1;
        bus.req_addr  = 10'd9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_rsp_data",  bus.rsp_data,       hold_d);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_mem_enable", 32'(bus.mem_enable), 32'd0);
        end
        chk("stall_no_access", 32'(en_rises - r0), 32'd0);
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the middle of WAIT
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd20;
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("wait_busy", 32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_mem_enable", 32'(bus.mem_enable), 32'd0);
        chk("rst_mid_busy",       32'(busy),           32'd0);
        @(negedge clk);
        reset = 1'b0;
        r0 = en_rises;
        do_req(1'b0, 10'd7, 32'h0, d, e);
        chk("post_rst_data", d, 32'd7);
        chk("post_rst_enable_rise", 32'(en_rises - r0), 32'd1);

        // Randomized traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom_range(0, 1));
            a   = 10'($urandom_range(0, 63));
            wd  = $urandom;
            exp = ref_mem[a];
            if (we) ref_mem[a] = wd;
            do_req(we, a, wd, d, e);
            chk($sformatf("rand%0d_data", i), d, exp);
            chk($sformatf("rand%0d_err", i), 32'(e), 32'd0);
        end

`ifdef MEM_REQ_TIMEOUT_EN
        kill_done = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 10'd3;
        k = 0;
        while (!bus.req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (!bus.rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("to_latency", 32'(k), 32'(TO_CYC + 1));
        chk("to_err",     32'(bus.rsp_err),  32'd1);
        chk("to_data",    bus.rsp_data,      32'd0);
        @(posedge clk);
        #1 kill_done = 1'b0;
        do_req(1'b0, 10'd3, 32'h0, d, e);
        chk("to_recover_data", d, ref_mem[3]);
        chk("to_recover_err",  32'(e), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
